// File: rtl/maindec_mc_ctrl_if.sv
// Control bundle between the multicycle main decoder and the datapath/memory.
// The master modport is the controller side; the slave modport is the datapath side.
interface maindec_mc_ctrl_if #(
  parameter int unsigned STATE_W = 5,
  parameter int unsigned ALUOP_W = 3
) ();
  logic [5:0]         op;
  logic               mem_ready;
  logic               mem_req;
  logic               memwrite;
  logic               iord;
  logic               irwrite;
  logic [1:0]         regdst;
  logic [1:0]         memtoreg;
  logic               regwrite;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [1:0]         pcsrc;
  logic [ALUOP_W-1:0] aluop;
  logic               branch;
  logic               bne;
  logic               pcwrite;
  logic [1:0]         ldsize;
  logic               ldsigned;
  logic               err;
  logic [STATE_W-1:0] st;

  modport master (
    input  op, mem_ready,
    output mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
           pcsrc, aluop, branch, bne, pcwrite, ldsize, ldsigned, err, st
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
           pcsrc, aluop, branch, bne, pcwrite, ldsize, ldsigned, err, st
  );
endinterface

// File: rtl/maindec_mc_ctrl.sv
// Multicycle MIPS main-control FSM with memory ready handshake, wait-state timeout and sub-word loads.
// Optional illegal-opcode trap enabled by defining MAINDEC_TRAP_EN.
module maindec_mc_ctrl #(
  parameter int unsigned STATE_W  = 5,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  maindec_mc_ctrl_if.master bus
);

  typedef enum logic [4:0] {
    StFetch  = 5'd0,
    StDecode = 5'd1,
    StMemAdr = 5'd2,
    StMemRd  = 5'd3,
    StMemWb  = 5'd4,
    StMemWr  = 5'd5,
    StRtEx   = 5'd6,
    StRtWb   = 5'd7,
    StBeq    = 5'd8,
    StIEx    = 5'd9,
    StIWb    = 5'd10,
    StJump   = 5'd11,
    StBne    = 5'd12,
    StJal    = 5'd13,
    StTrap   = 5'd14,
    StHalt   = 5'd15
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpLb    = 6'b100000;
  localparam logic [5:0] OpLbu   = 6'b100100;
  localparam logic [5:0] OpLh    = 6'b100001;
  localparam logic [5:0] OpLhu   = 6'b100101;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [ALUOP_W-1:0] AluAdd   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AluSub   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AluFunct = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AluAnd   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] AluOr    = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] AluSlt   = ALUOP_W'(5);

  localparam logic [WAIT_W-1:0] WaitMax = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;

  logic   mem_access;
  state_e mem_done_state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StFetch;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_d         = '0;
    err_d          = err_q;
    mem_access     = 1'b0;
    mem_done_state = StFetch;
    case (state_q)
      StFetch: begin
        mem_access     = 1'b1;
        mem_done_state = StDecode;
      end
      StDecode: begin
        case (bus.op)
          OpRtype:                                   state_d = StRtEx;
          OpLw, OpSw, OpLb, OpLbu, OpLh, OpLhu:      state_d = StMemAdr;
          OpBeq:                                     state_d = StBeq;
          OpBne:                                     state_d = StBne;
          OpAddi, OpAndi, OpOri, OpSlti:             state_d = StIEx;
          OpJ:                                       state_d = StJump;
          OpJal:                                     state_d = StJal;
`ifdef MAINDEC_TRAP_EN
          default:                                   state_d = StTrap;
`else
          default:                                   state_d = StFetch;
`endif
        endcase
      end
      StMemAdr: state_d = (bus.op == OpSw) ? StMemWr : StMemRd;
      StMemRd: begin
        mem_access     = 1'b1;
        mem_done_state = StMemWb;
      end
      StMemWr: begin
        mem_access     = 1'b1;
        mem_done_state = StFetch;
      end
      StMemWb, StRtWb, StIWb, StBeq, StBne, StJump, StJal: state_d = StFetch;
      StRtEx:  state_d = StRtWb;
      StIEx:   state_d = StIWb;
      StTrap: begin
        state_d = StHalt;
        err_d   = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase

    // A ready on the timeout cycle still completes the access normally.
    if (mem_access) begin
      if (bus.mem_ready) begin
        state_d = mem_done_state;
      end else if (wait_q == WaitMax) begin
        state_d = StHalt;
        err_d   = 1'b1;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  logic               mem_req, memwrite, iord, irwrite, regwrite, alusrca;
  logic               branch, bne, pcwrite, ldsigned;
  logic [1:0]         regdst, memtoreg, alusrcb, pcsrc, ldsize;
  logic [ALUOP_W-1:0] aluop;
  logic [1:0]         op_ldsize;
  logic               op_ldsigned;

  always_comb begin
    op_ldsize   = 2'b00;
    op_ldsigned = 1'b0;
    case (bus.op)
      OpLb:    begin op_ldsize = 2'b01; op_ldsigned = 1'b1; end
      OpLbu:   begin op_ldsize = 2'b01; op_ldsigned = 1'b0; end
      OpLh:    begin op_ldsize = 2'b10; op_ldsigned = 1'b1; end
      OpLhu:   begin op_ldsize = 2'b10; op_ldsigned = 1'b0; end
      default: begin op_ldsize = 2'b00; op_ldsigned = 1'b0; end
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    regdst   = 2'b00;
    memtoreg = 2'b00;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = AluAdd;
    branch   = 1'b0;
    bne      = 1'b0;
    pcwrite  = 1'b0;
    ldsize   = 2'b00;
    ldsigned = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = bus.mem_ready;
        pcwrite = bus.mem_ready;
      end
      StDecode: alusrcb = 2'b11;
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        ldsize   = op_ldsize;
        ldsigned = op_ldsigned;
      end
      StMemWb: begin
        memtoreg = 2'b01;
        regwrite = 1'b1;
        ldsize   = op_ldsize;
        ldsigned = op_ldsigned;
      end
      StMemWr: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      StRtEx: begin
        alusrca = 1'b1;
        aluop   = AluFunct;
      end
      StRtWb: begin
        regdst   = 2'b01;
        regwrite = 1'b1;
      end
      StIEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (bus.op)
          OpAndi:  aluop = AluAnd;
          OpOri:   aluop = AluOr;
          OpSlti:  aluop = AluSlt;
          default: aluop = AluAdd;
        endcase
      end
      StIWb: regwrite = 1'b1;
      StBeq, StBne: begin
        alusrca = 1'b1;
        aluop   = AluSub;
        pcsrc   = 2'b01;
        branch  = (state_q == StBeq);
        bne     = (state_q == StBne);
      end
      StJump: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      StJal: begin
        regdst   = 2'b10;
        memtoreg = 2'b10;
        regwrite = 1'b1;
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.mem_req  = mem_req;
  assign bus.memwrite = memwrite;
  assign bus.iord     = iord;
  assign bus.irwrite  = irwrite;
  assign bus.regdst   = regdst;
  assign bus.memtoreg = memtoreg;
  assign bus.regwrite = regwrite;
  assign bus.alusrca  = alusrca;
  assign bus.alusrcb  = alusrcb;
  assign bus.pcsrc    = pcsrc;
  assign bus.aluop    = aluop;
  assign bus.branch   = branch;
  assign bus.bne      = bne;
  assign bus.pcwrite  = pcwrite;
  assign bus.ldsize   = ldsize;
  assign bus.ldsigned = ldsigned;
  assign bus.err      = err_q;
  assign bus.st       = STATE_W'(state_q);

endmodule
